win_checker: RTL and testbench
==============================

WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 SHALL have parameter ROWS, default 6, board rows; row 0 top, row ROWS-1 bottom; supported range 4..8.
REQ-002 SHALL have parameter COLS, default 7, board columns; column 0 leftmost; supported range 4..8.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to scan; issued by the drop controller when its drop completes.
REQ-006 player  input  1  board to scan: 0 selects board0, 1 selects board1.
REQ-007 board0  input  [ROWS-1:0][COLS-1:0]  player-0 occupancy; board0[r][c]=1 means a piece at row r, column c.
REQ-008 board1  input  [ROWS-1:0][COLS-1:0]  player-1 occupancy, same indexing as board0.
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 done  output  1  one-cycle pulse at scan completion.
REQ-011 win  output  1  selected player has four in a row.
REQ-012 draw  output  1  every cell occupied and win=0.
REQ-013 winner  output  1  player value latched at start.
REQ-014 winRow  output  3  anchor row of the winning line.
REQ-015 winCol  output  3  anchor column of the winning line.
REQ-016 winDir  output  2  line direction: 0 = +col, 1 = +row, 2 = +row+col, 3 = +row-col.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-018 IDLE: start=1 at a rising edge (edge 0) SHALL snapshot the selected board and the OR of both boards, latch winner=player, clear win/draw/winRow/winCol/winDir, set anchor (0,0), and enter SCAN.
REQ-019 SCAN: each rising edge SHALL evaluate exactly one anchor, in raster order: index k = r*COLS + c, with column incrementing fastest.
REQ-020 Anchor evaluation SHALL test four cells from the anchor in each of the four directions; a cell outside the board counts as empty, with no wrap across rows or columns.
REQ-021 If an anchor wins in several directions, SHALL report the lowest winDir code.
REQ-022 First winning anchor k, evaluated at edge k+1: SHALL latch win=1, winRow=r, winCol=c, winDir, then enter DONE (early termination).
REQ-023 No win after the last anchor (k = ROWS*COLS-1): SHALL latch draw=1 if the snapshot OR is all ones, else draw=0; then enter DONE.
REQ-024 DONE: done=1 for exactly one cycle, then return to IDLE; done is high in the cycle after edge k+1, where k is the winning anchor index or ROWS*COLS-1.
REQ-025 busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-026 start while busy=1 SHALL be ignored: no restart, no queuing.
REQ-027 Board input changes after edge 0 SHALL NOT affect the current result, because the scan uses only the snapshot.
REQ-028 win, draw, winner, winRow, winCol, winDir SHALL hold their values from DONE until the next accepted start or reset.
REQ-029 Row and column counters SHALL be 3 bits; the column counter wraps COLS-1 -> 0 while the row counter increments.

Reset
REQ-030 reset=1 SHALL immediately force IDLE and set busy, done, win, draw, winner, winRow, winCol, winDir and the counters to 0.
REQ-031 reset during SCAN or DONE SHALL abort the scan, with no done pulse afterwards.
REQ-032 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-033 Empty boards, start player=0 -> done pulses after edge 42, win=0, draw=0; busy high for 43 cycles.
REQ-034 board0 row 5 cols 0-3 set, plus row 1 cols 5,6 and row 2 cols 0,1 (a non-wrap decoy), start player=0 -> win=1, winRow=5, winCol=0, winDir=0, done after edge 36.
REQ-035 board1 col 6 rows 2-5 set, start player=1 -> win=1, winner=1, winRow=2, winCol=6, winDir=1, done after edge 21; same board with player=0 -> win=0.
REQ-036 board0 cells (0,3),(1,2),(2,1),(3,0) set, start player=0 -> winRow=0, winCol=3, winDir=3, done after edge 4; board inputs cleared at edge 2 -> result unchanged.
REQ-037 board0 all zeros, board1 all ones, start player=0 -> win=0, draw=1, done after edge 42.
REQ-038 start pulsed again at edge 10 of a scan -> ignored, single done; reset asserted at edge 20 -> all outputs 0, no done, and the next start scans normally.

Source files
------------

// File: rtl/win_checker.sv
// win_checker: scans one player's Connect-Four style board for four in a row.
//
// A start pulse in IDLE snapshots the selected board together with the OR of
// both boards. SCAN then walks one anchor per clock in raster order,
// column fastest. The first anchor that completes a line of four ends the
// scan early. If no anchor wins, the last anchor decides draw from the
// occupancy snapshot. DONE raises a one-cycle done pulse and returns to IDLE.
// The result outputs hold until the next accepted start or reset.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   start, player  scan request and board select (0: board0, 1: board1)
//   board0/board1  per-player occupancy, [row][col], row 0 at the top
//   busy, done     scan in progress / one-cycle completion pulse
//   win, draw      result flags
//   winner         player latched at start
//   winRow/winCol  anchor of the winning line
//   winDir         0 +col, 1 +row, 2 +row+col, 3 +row-col

// Builds, for one direction, a map of every anchor whose four cells are all
// set. Bounds are resolved at elaboration time, so a cell off the board is a
// constant 0 and lines can never wrap across rows or columns.
module win_dir_map #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int DR   = 0,
  parameter int DC   = 1
) (
  input  logic [ROWS-1:0][COLS-1:0] board,
  output logic [ROWS-1:0][COLS-1:0] hit_map
);
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] cells;
      for (genvar i = 0; i < 4; i++) begin : g_cell
        localparam int RR = r + i * DR;
        localparam int CC = c + i * DC;
        if (RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS) begin : g_in
          assign cells[i] = board[RR][CC];
        end else begin : g_out
          assign cells[i] = 1'b0;
        end
      end
      assign hit_map[r][c] = &cells;
    end
  end
endmodule

module win_checker #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      player,
  input  logic [ROWS-1:0][COLS-1:0] board0,
  input  logic [ROWS-1:0][COLS-1:0] board1,
  output logic                      busy,
  output logic                      done,
  output logic                      win,
  output logic                      draw,
  output logic                      winner,
  output logic [2:0]                winRow,
  output logic [2:0]                winCol,
  output logic [1:0]                winDir
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [ROWS-1:0][COLS-1:0] snap_q, snap_d;
  logic [ROWS-1:0][COLS-1:0] occ_q, occ_d;
  logic [2:0]                row_q, row_d;
  logic [2:0]                col_q, col_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      win_q, win_d;
  logic                      draw_q, draw_d;
  logic                      winner_q, winner_d;
  logic [2:0]                win_row_q, win_row_d;
  logic [2:0]                win_col_q, win_col_d;
  logic [1:0]                win_dir_q, win_dir_d;

  // One hit map per direction, evaluated on the snapshot.
  logic [3:0][ROWS-1:0][COLS-1:0] hit_maps;
  logic [3:0]                     hit;

  for (genvar d = 0; d < 4; d++) begin : g_dir
    localparam int DR = (d == 0) ? 0 : 1;
    localparam int DC = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
    win_dir_map #(.ROWS(ROWS), .COLS(COLS), .DR(DR), .DC(DC)) u_map (
      .board   (snap_q),
      .hit_map (hit_maps[d])
    );
    assign hit[d] = hit_maps[d][row_q][col_q];
  end

  logic last_anchor;
  assign last_anchor = (row_q == 3'(ROWS - 1)) && (col_q == 3'(COLS - 1));

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    occ_d     = occ_q;
    row_d     = row_q;
    col_d     = col_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    win_d     = win_q;
    draw_d    = draw_q;
    winner_d  = winner_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    win_dir_d = win_dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d    = player ? board1 : board0;
          occ_d     = board0 | board1;
          winner_d  = player;
          win_d     = 1'b0;
          draw_d    = 1'b0;
          win_row_d = '0;
          win_col_d = '0;
          win_dir_d = '0;
          row_d     = '0;
          col_d     = '0;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (|hit) begin
          win_d     = 1'b1;
          win_row_d = row_q;
          win_col_d = col_q;
          // Lowest direction code wins a tie.
          if (hit[0])      win_dir_d = 2'd0;
          else if (hit[1]) win_dir_d = 2'd1;
          else if (hit[2]) win_dir_d = 2'd2;
          else             win_dir_d = 2'd3;
          done_d    = 1'b1;
          state_d   = DONE;
        end else if (last_anchor) begin
          draw_d  = &occ_q;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (col_q == 3'(COLS - 1)) begin
          col_d = '0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      occ_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      draw_q    <= 1'b0;
      winner_q  <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
      win_dir_q <= '0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      occ_q     <= occ_d;
      row_q     <= row_d;
      col_q     <= col_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      win_q     <= win_d;
      draw_q    <= draw_d;
      winner_q  <= winner_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      win_dir_q <= win_dir_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign win    = win_q;
  assign draw   = draw_q;
  assign winner = winner_q;
  assign winRow = win_row_q;
  assign winCol = win_col_q;
  assign winDir = win_dir_q;
endmodule

// File: tb/tb_win_checker.sv
// Directed bench for win_checker at the default 6x7 board size.
module tb_win_checker;
  localparam int ROWS = 6;
  localparam int COLS = 7;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic                      player;
  logic [ROWS-1:0][COLS-1:0] board0, board1;
  logic                      busy, done, win, draw, winner;
  logic [2:0]                winRow, winCol;
  logic [1:0]                winDir;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  win_checker #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .player (player),
    .board0 (board0),
    .board1 (board1),
    .busy   (busy),
    .done   (done),
    .win    (win),
    .draw   (draw),
    .winner (winner),
    .winRow (winRow),
    .winCol (winCol),
    .winDir (winDir)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues start at edge 0, then watches 60 further edges.
  // clr_e: boards cleared before that edge; rst_e: reset held across that
  // edge; rs_e: start pulsed again at that edge.
  task automatic do_scan(input logic p, input int clr_e, input int rs_e,
                         input int rst_e, output int done_edge,
                         output int busy_cyc, output int n_done);
    @(negedge clk);
    player = p;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cyc  = busy ? 1 : 0;
    done_edge = -1;
    n_done    = 0;
    for (int e = 1; e <= 60; e++) begin
      start = (e == rs_e);
      reset = (e == rst_e);
      if (e == clr_e) begin
        board0 = '0;
        board1 = '0;
      end
      @(posedge clk);
      #1;
      if (busy) busy_cyc++;
      if (done) begin
        n_done++;
        if (done_edge < 0) done_edge = e;
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int w, input int dr,
                            input int wr, input int wc, input int wd);
    chk({tag, "_win"}, int'(win), w);
    chk({tag, "_draw"}, int'(draw), dr);
    if (w == 1) begin
      chk({tag, "_row"}, int'(winRow), wr);
      chk({tag, "_col"}, int'(winCol), wc);
      chk({tag, "_dir"}, int'(winDir), wd);
    end
  endtask

  int de, bc, nd;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    player = 1'b0;
    board0 = '0;
    board1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_draw", int'(draw), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_row", int'(winRow), 0);
    chk("rst_col", int'(winCol), 0);
    chk("rst_dir", int'(winDir), 0);
    @(negedge clk);
    reset = 1'b0;

    // Empty boards: full scan, no win, no draw.
    do_scan(1'b0, -1, -1, -1, de, bc, nd);
    chk("empty_edge", de, 42);
    chk("empty_busy", bc, 43);
    chk("empty_ndone", nd, 1);
    chk_result("empty", 0, 0, 0, 0, 0);

    // Horizontal bottom row plus a row-wrap decoy ending row 1.
    board0 = '0; board1 = '0;
    board0[5][3:0] = 4'hf;
    board0[1][5] = 1'b1; board0[1][6] = 1'b1;
    board0[2][0] = 1'b1; board0[2][1] = 1'b1;
    do_scan(1'b0, -1, -1, -1, de, bc, nd);
    chk("horiz_edge", de, 36);
    chk("horiz_busy", bc, 37);
    chk_result("horiz", 1, 0, 5, 0, 0);

    // Vertical line in the rightmost column, player 1.
    board0 = '0; board1 = '0;
    for (int r = 2; r < 6; r++) board1[r][6] = 1'b1;
    do_scan(1'b1, -1, -1, -1, de, bc, nd);
    chk("vert_edge", de, 21);
    chk("vert_winner", int'(winner), 1);
    chk_result("vert", 1, 0, 2, 6, 1);
    // Same boards scanned for player 0: nothing there.
    do_scan(1'b0, -1, -1, -1, de, bc, nd);
    chk("vert_p0_edge", de, 42);
    chk("vert_p0_winner", int'(winner), 0);
    chk_result("vert_p0", 0, 0, 0, 0, 0);

    // Anti-diagonal; inputs cleared mid-scan must not matter.
    board0 = '0; board1 = '0;
    board0[0][3] = 1'b1; board0[1][2] = 1'b1;
    board0[2][1] = 1'b1; board0[3][0] = 1'b1;
    do_scan(1'b0, 2, -1, -1, de, bc, nd);
    chk("anti_edge", de, 4);
    chk_result("anti", 1, 0, 0, 3, 3);

    // Main diagonal reaching the bottom-right corner.
    board0 = '0; board1 = '0;
    for (int i = 0; i < 4; i++) board1[2+i][3+i] = 1'b1;
    do_scan(1'b1, -1, -1, -1, de, bc, nd);
    chk("diag_edge", de, 18);
    chk_result("diag", 1, 0, 2, 3, 2);

    // Anchor (0,0) wins horizontally and vertically: lowest code reported.
    board0 = '0; board1 = '0;
    board0[0][3:0] = 4'hf;
    for (int r = 0; r < 4; r++) board0[r][0] = 1'b1;
    do_scan(1'b0, -1, -1, -1, de, bc, nd);
    chk("tie_edge", de, 1);
    chk_result("tie", 1, 0, 0, 0, 0);

    // Full occupancy from the other player: draw.
    board0 = '0; board1 = '1;
    do_scan(1'b0, -1, -1, -1, de, bc, nd);
    chk("draw_edge", de, 42);
    chk_result("draw", 0, 1, 0, 0, 0);

    // Second start during a scan is ignored.
    board0 = '0; board1 = '0;
    board0[5][3:0] = 4'hf;
    do_scan(1'b0, -1, 10, -1, de, bc, nd);
    chk("restart_edge", de, 36);
    chk("restart_ndone", nd, 1);
    chk_result("restart", 1, 0, 5, 0, 0);

    // Reset mid-scan aborts with no done pulse.
    do_scan(1'b0, -1, -1, 20, de, bc, nd);
    chk("abort_ndone", nd, 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_win", int'(win), 0);
    chk("abort_row", int'(winRow), 0);

    // Next start after reset scans normally.
    do_scan(1'b0, -1, -1, -1, de, bc, nd);
    chk("post_edge", de, 36);
    chk_result("post", 1, 0, 5, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
